// File: rtl/x_stage.sv
// Execute stage: ALU, branch-target adder and destination select into one output register.
// Latency: 1 cycle, outputs registered on clk. Optional SLT/SLTU under `X_STAGE_SLT_EN.
// Backpressure: none; a new instruction is accepted every cycle, no stall or handshake.
module x_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  op,
    input  logic        reg_dst,
    input  logic        aluSrc,
    input  logic [31:0] pc,
    input  logic [31:0] immediate,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    output logic        zero,
    output logic [31:0] pc_branch,
    output logic [31:0] alu_out,
    output logic [31:0] rt_val_out,
    output logic [4:0]  reg_dst_addr
);

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU = 6'h2B;

    logic [31:0] operand_b;
    logic [31:0] alu_res;
    logic [31:0] slt_res;
    logic [31:0] sltu_res;
    logic [31:0] branch_tgt;
    logic [5:0]  funct;

    assign operand_b  = aluSrc ? immediate : rt_val;
    assign funct      = immediate[5:0];
    // Word-offset branch: the two top immediate bits fall off, wrapping modulo 2^32.
    assign branch_tgt = pc + {immediate[29:0], 2'b00};

`ifdef X_STAGE_SLT_EN
    assign slt_res  = {31'd0, $signed(rs_val) < $signed(operand_b)};
    assign sltu_res = {31'd0, rs_val < operand_b};
`else
    assign slt_res  = '0;
    assign sltu_res = '0;
`endif

    always_comb begin
        alu_res = '0;
        case (op)
            2'b00: begin
                case (funct)
                    FUNCT_ADD:  alu_res = rs_val + operand_b;
                    FUNCT_SUB:  alu_res = rs_val - operand_b;
                    FUNCT_AND:  alu_res = rs_val & operand_b;
                    FUNCT_OR:   alu_res = rs_val | operand_b;
                    FUNCT_SLT:  alu_res = slt_res;
                    FUNCT_SLTU: alu_res = sltu_res;
                    default:    alu_res = '0;
                endcase
            end
            2'b01: alu_res = rs_val + operand_b;
            2'b10: alu_res = rs_val - operand_b;
            2'b11: alu_res = rs_val + operand_b;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero         <= 1'b0;
            pc_branch    <= '0;
            alu_out      <= '0;
            rt_val_out   <= '0;
            reg_dst_addr <= '0;
        end else begin
            zero         <= (alu_res == 32'd0);
            pc_branch    <= branch_tgt;
            alu_out      <= alu_res;
            rt_val_out   <= rt_val;
            reg_dst_addr <= reg_dst ? rd_addr : rt_addr;
        end
    end

endmodule

// File: tb/tb_x_stage.sv
// Testbench for x_stage: directed vectors, async reset checks and a seeded random sweep
// against a one-cycle-delayed scoreboard.
module tb_x_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  op;
    logic        reg_dst;
    logic        aluSrc;
    logic [31:0] pc;
    logic [31:0] immediate;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic        zero;
    logic [31:0] pc_branch;
    logic [31:0] alu_out;
    logic [31:0] rt_val_out;
    logic [4:0]  reg_dst_addr;

    typedef struct packed {
        logic        z;
        logic [31:0] pcb;
        logic [31:0] alu;
        logic [31:0] rtv;
        logic [4:0]  dst;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    x_stage dut (
        .clk          (clk),
        .rst          (rst),
        .op           (op),
        .reg_dst      (reg_dst),
        .aluSrc       (aluSrc),
        .pc           (pc),
        .immediate    (immediate),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .rt_addr      (rt_addr),
        .rd_addr      (rd_addr),
        .zero         (zero),
        .pc_branch    (pc_branch),
        .alu_out      (alu_out),
        .rt_val_out   (rt_val_out),
        .reg_dst_addr (reg_dst_addr)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic z, input logic [31:0] pcb, input logic [31:0] alu,
                                input logic [31:0] rtv, input logic [4:0] dst);
        exp_t e;
        e.z = z; e.pcb = pcb; e.alu = alu; e.rtv = rtv; e.dst = dst;
        return e;
    endfunction

    // Reference model used for the random sweep.
    function automatic exp_t model(input logic [1:0] o, input logic rd, input logic as,
                                   input logic [31:0] p, input logic [31:0] im,
                                   input logic [31:0] a, input logic [31:0] rt,
                                   input logic [4:0] ra, input logic [4:0] rda);
        logic [31:0] b;
        logic [31:0] r;
        b = as ? im : rt;
        r = 32'd0;
        if (o == 2'b10) r = a - b;
        else if (o != 2'b00) r = a + b;
        else if (im[5:0] == 6'h20) r = a + b;
        else if (im[5:0] == 6'h22) r = a - b;
        else if (im[5:0] == 6'h24) r = a & b;
        else if (im[5:0] == 6'h25) r = a | b;
`ifdef X_STAGE_SLT_EN
        else if (im[5:0] == 6'h2A) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        else if (im[5:0] == 6'h2B) r = (a < b) ? 32'd1 : 32'd0;
`endif
        return mk(r == 32'd0, p + im * 32'd4, r, rt, rd ? rda : ra);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, e.z});
        check({tag, "_pcb"},  pc_branch,     e.pcb);
        check({tag, "_alu"},  alu_out,       e.alu);
        check({tag, "_rtv"},  rt_val_out,    e.rtv);
        check({tag, "_dst"},  {27'd0, reg_dst_addr}, {27'd0, e.dst});
    endtask

    task automatic set_in(input logic [1:0] o, input logic rd, input logic as,
                          input logic [31:0] p, input logic [31:0] im,
                          input logic [31:0] a, input logic [31:0] rt,
                          input logic [4:0] ra, input logic [4:0] rda);
        op = o; reg_dst = rd; aluSrc = as; pc = p; immediate = im;
        rs_val = a; rt_val = rt; rt_addr = ra; rd_addr = rda;
    endtask

    task automatic drive(input string tag, input logic [1:0] o, input logic rd, input logic as,
                         input logic [31:0] p, input logic [31:0] im,
                         input logic [31:0] a, input logic [31:0] rt,
                         input logic [4:0] ra, input logic [4:0] rda, input exp_t e);
        exp_t got;
        @(negedge clk);
        set_in(o, rd, as, p, im, a, rt, ra, rda);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end else begin
            got = sb.pop_front();
            check_out(tag, got);
        end
    endtask

    initial begin
        exp_t e;
        logic [5:0] funct_tbl [6];
        funct_tbl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};

        rst = 1'b1;
        set_in(2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        #1;
        check_out("reset_init", mk(1'b0, 32'd0, 32'd0, 32'd0, 5'd0));
        // Nonzero inputs across an edge while reset is held must not be captured.
        set_in(2'b01, 1'b1, 1'b1, 32'h40, 32'd5, 32'd7, 32'd9, 5'd3, 5'd4);
        @(posedge clk);
        #1;
        check_out("reset_held", mk(1'b0, 32'd0, 32'd0, 32'd0, 5'd0));
        @(negedge clk);
        rst = 1'b0;

        drive("r_add", 2'b00, 1'b1, 1'b0, 32'h100, 32'h20, 32'd4, 32'd4, 5'd31, 5'd0,
              mk(1'b0, 32'h180, 32'd8, 32'd4, 5'd0));
        drive("r_sub", 2'b00, 1'b1, 1'b0, 32'h200, 32'hFF000022, 32'd4, 32'd4, 5'd6, 5'd5,
              mk(1'b1, 32'hFC000288, 32'd0, 32'd4, 5'd5));
        drive("r_and", 2'b00, 1'b0, 1'b0, 32'h0, 32'hFF000024, 32'hFFFFFFFF, 32'hF0F0F0F0, 5'd7, 5'd1,
              mk(1'b0, 32'hFC000090, 32'hF0F0F0F0, 32'hF0F0F0F0, 5'd7));
        drive("r_or", 2'b00, 1'b1, 1'b0, 32'h10, 32'hFF000025, 32'hF0F0F0F0, 32'h0F0F0F0F, 5'd2, 5'd3,
              mk(1'b0, 32'hFC0000A4, 32'hFFFFFFFF, 32'h0F0F0F0F, 5'd3));

        // Asynchronous reset between edges while outputs are nonzero.
        #2;
        rst = 1'b1;
        #1;
        check_out("rst_async", mk(1'b0, 32'd0, 32'd0, 32'd0, 5'd0));
        @(posedge clk);
        #1;
        check_out("rst_hold", mk(1'b0, 32'd0, 32'd0, 32'd0, 5'd0));
        @(negedge clk);
        rst = 1'b0;

        drive("addi", 2'b01, 1'b0, 1'b1, 32'h0, 32'd15, 32'd17, 32'd199, 5'd31, 5'd2,
              mk(1'b0, 32'd60, 32'd32, 32'd199, 5'd31));
        drive("bne_eq", 2'b10, 1'b0, 1'b0, 32'd1000, 32'd1, 32'd15, 32'd15, 5'd4, 5'd9,
              mk(1'b1, 32'd1004, 32'd0, 32'd15, 5'd4));
        drive("bne_ne", 2'b10, 1'b0, 1'b0, 32'd1000, 32'd1, 32'd16, 32'd15, 5'd4, 5'd9,
              mk(1'b0, 32'd1004, 32'd1, 32'd15, 5'd4));
        drive("r_undef", 2'b00, 1'b1, 1'b0, 32'h0, 32'h21, 32'd5, 32'd3, 5'd1, 5'd8,
              mk(1'b1, 32'h84, 32'd0, 32'd3, 5'd8));
`ifdef X_STAGE_SLT_EN
        drive("r_slt", 2'b00, 1'b1, 1'b0, 32'h0, 32'h2A, 32'hFFFFFFFF, 32'd1, 5'd1, 5'd10,
              mk(1'b0, 32'hA8, 32'd1, 32'd1, 5'd10));
        drive("r_sltu", 2'b00, 1'b1, 1'b0, 32'h0, 32'h2B, 32'd1, 32'hFFFFFFFF, 5'd1, 5'd11,
              mk(1'b0, 32'hAC, 32'd1, 32'hFFFFFFFF, 5'd11));
`else
        drive("r_slt", 2'b00, 1'b1, 1'b0, 32'h0, 32'h2A, 32'hFFFFFFFF, 32'd1, 5'd1, 5'd10,
              mk(1'b1, 32'hA8, 32'd0, 32'd1, 5'd10));
        drive("r_sltu", 2'b00, 1'b1, 1'b0, 32'h0, 32'h2B, 32'd1, 32'hFFFFFFFF, 5'd1, 5'd11,
              mk(1'b1, 32'hAC, 32'd0, 32'hFFFFFFFF, 5'd11));
`endif
        drive("mem_wrap", 2'b11, 1'b0, 1'b1, 32'h0, 32'd1, 32'hFFFFFFFF, 32'd0, 5'd12, 5'd13,
              mk(1'b1, 32'd4, 32'd0, 32'd0, 5'd12));
        drive("addi_wrap", 2'b01, 1'b1, 1'b1, 32'hFFFFFFFC, 32'd1, 32'hFFFFFFFF, 32'd6, 5'd12, 5'd13,
              mk(1'b1, 32'd0, 32'd0, 32'd6, 5'd13));
        drive("sub_wrap", 2'b10, 1'b0, 1'b0, 32'h8, 32'hFFFFFFFF, 32'd0, 32'd1, 5'd14, 5'd15,
              mk(1'b0, 32'h4, 32'hFFFFFFFF, 32'd1, 5'd14));

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic        rd, as;
            logic [31:0] p, im, a, rt;
            logic [4:0]  ra, rda;
            o  = 2'($urandom_range(0, 3));
            rd = 1'($urandom_range(0, 1));
            as = 1'($urandom_range(0, 1));
            p  = $urandom;
            im = $urandom;
            im[5:0] = funct_tbl[$urandom_range(0, 5)];
            a  = $urandom;
            rt = (i % 5 == 0) ? 32'd0 - (as ? im : a) : $urandom;
            if (i % 5 == 0) a = 32'd0 - (as ? im : rt);
            ra  = 5'($urandom_range(0, 31));
            rda = 5'($urandom_range(0, 31));
            e = model(o, rd, as, p, im, a, rt, ra, rda);
            drive("rand", o, rd, as, p, im, a, rt, ra, rda, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
